// File: rtl/shared_ram_arbiter.sv
// ----------------------------------------------------------------------------
// shared_ram_arbiter
// Arbitrates main-CPU and sub-CPU access to the single-port shared work RAM.
// Each access holds the RAM bus for ACCESS_CYCLES clocks. It then returns a
// one-cycle ack, plus read data for reads. The per-CPU wait lines let the
// clock generator stretch the CPU bus cycle until that ack arrives.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> main CPU always wins a simultaneous request
//                      undefined -> round-robin on ties (default)
//
// Ports:
//   CLK_48M                    system clock, rising edge
//   rst                        synchronous reset, active-low
//   req_m/we_m/addr_m/din_m    main-CPU request, direction, address, write data
//   req_s/we_s/addr_s/din_s    sub-CPU request, direction, address, write data
//   ram_dout                   RAM read data
//   ram_cs/ram_we              RAM select / write strobe
//   ram_addr/ram_din           RAM address / write data
//   dout_m/dout_s              per-CPU read data, held until that CPU's next read
//   ack_m/ack_s                one-cycle access-complete pulse
//   wait_m/wait_s              combinational: request pending and not yet served
// ----------------------------------------------------------------------------
module shared_ram_arbiter #(
    parameter int unsigned ADDR_W        = 11,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ACCESS_CYCLES = 4
) (
    input  logic              CLK_48M,
    input  logic              rst,
    input  logic              req_m,
    input  logic              we_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] din_m,
    input  logic              req_s,
    input  logic              we_s,
    input  logic [ADDR_W-1:0] addr_s,
    input  logic [DATA_W-1:0] din_s,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic [DATA_W-1:0] dout_m,
    output logic [DATA_W-1:0] dout_s,
    output logic              ack_m,
    output logic              ack_s,
    output logic              wait_m,
    output logic              wait_s
);

    localparam int unsigned    CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_M = 2'd1,
        GRANT_S = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [ADDR_W-1:0]  ram_addr_q;
    logic [DATA_W-1:0]  ram_din_q;
    logic               ram_cs_q;
    logic               ram_we_q;
    logic [DATA_W-1:0]  dout_m_q;
    logic [DATA_W-1:0]  dout_s_q;
    logic               ack_m_q;
    logic               ack_s_q;
    logic               armed_m_q;
    logic               armed_s_q;
    logic               last_grant_s_q;

    logic               armed_m_d;
    logic               armed_s_d;
    logic               elig_m;
    logic               elig_s;
    logic               pick_m;
    logic               pick_s;
    logic               last_cycle;

    // Arbitration decision and re-arm bookkeeping.
    always_comb begin
        elig_m     = req_m & armed_m_q;
        elig_s     = req_s & armed_s_q;
        pick_m     = 1'b0;
        pick_s     = 1'b0;
        last_cycle = (state_q != IDLE) && (cnt_q == '0);

        if (state_q == IDLE) begin
            if (elig_m && elig_s) begin
`ifdef ARB_FIXED_PRIO_EN
                pick_m = 1'b1;
`else
                // Round-robin: the side that did not win last time goes first.
                pick_m = last_grant_s_q;
                pick_s = !last_grant_s_q;
`endif
            end else begin
                pick_m = elig_m;
                pick_s = elig_s;
            end
        end

        // A low request re-arms; completion disarms so a held request is served once.
        if (!req_m) begin
            armed_m_d = 1'b1;
        end else if (last_cycle && (state_q == GRANT_M)) begin
            armed_m_d = 1'b0;
        end else begin
            armed_m_d = armed_m_q;
        end

        if (!req_s) begin
            armed_s_d = 1'b1;
        end else if (last_cycle && (state_q == GRANT_S)) begin
            armed_s_d = 1'b0;
        end else begin
            armed_s_d = armed_s_q;
        end
    end

    // Access sequencer: grant, hold the RAM bus for ACCESS_CYCLES clocks, then ack.
    always_ff @(posedge CLK_48M) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            ram_addr_q     <= '0;
            ram_din_q      <= '0;
            ram_cs_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            dout_m_q       <= '0;
            dout_s_q       <= '0;
            ack_m_q        <= 1'b0;
            ack_s_q        <= 1'b0;
            armed_m_q      <= 1'b1;
            armed_s_q      <= 1'b1;
            last_grant_s_q <= 1'b1;
        end else begin
            ack_m_q   <= 1'b0;
            ack_s_q   <= 1'b0;
            armed_m_q <= armed_m_d;
            armed_s_q <= armed_s_d;

            case (state_q)
                IDLE: begin
                    if (pick_m) begin
                        state_q        <= GRANT_M;
                        ram_addr_q     <= addr_m;
                        ram_din_q      <= din_m;
                        we_q           <= we_m;
                        ram_we_q       <= we_m;
                        ram_cs_q       <= 1'b1;
                        cnt_q          <= CNT_LOAD;
                        last_grant_s_q <= 1'b0;
                    end else if (pick_s) begin
                        state_q        <= GRANT_S;
                        ram_addr_q     <= addr_s;
                        ram_din_q      <= din_s;
                        we_q           <= we_s;
                        ram_we_q       <= we_s;
                        ram_cs_q       <= 1'b1;
                        cnt_q          <= CNT_LOAD;
                        last_grant_s_q <= 1'b1;
                    end
                end

                GRANT_M, GRANT_S: begin
                    if (cnt_q == '0) begin
                        state_q  <= IDLE;
                        ram_cs_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        if (state_q == GRANT_M) begin
                            ack_m_q <= 1'b1;
                            if (!we_q) begin
                                dout_m_q <= ram_dout;
                            end
                        end else begin
                            ack_s_q <= 1'b1;
                            if (!we_q) begin
                                dout_s_q <= ram_dout;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        // Strobe drops one cycle early so the address is stable at its trailing edge.
                        ram_we_q <= we_q && (cnt_q != CNT_W'(1));
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_cs   = ram_cs_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign dout_m   = dout_m_q;
    assign dout_s   = dout_s_q;
    assign ack_m    = ack_m_q;
    assign ack_s    = ack_s_q;

    // Wait is forced low while reset is asserted so every output reads 0 in reset.
    assign wait_m = rst & req_m & armed_m_q;
    assign wait_s = rst & req_s & armed_s_q;

endmodule
